// File: rtl/collatz_wb_ctrl.sv
// collatz_wb_ctrl: Wishbone control and result-capture stage wrapped around the collatz core.
// Optional run timeout is compiled in with `define COLLATZ_WB_CTRL_TIMEOUT_EN.
module collatz_wb_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [3:0]  wbs_sel_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        st_o,
    output logic [15:0] co_o,
    input  logic [15:0] x_i,
    input  logic        bs_i,
    output logic        irq_o
);
    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT_BUSY, S_RUN} state_t;

    localparam logic [2:0] A_CTRL   = 3'd0;
    localparam logic [2:0] A_SEED   = 3'd1;
    localparam logic [2:0] A_STEPS  = 3'd2;
    localparam logic [2:0] A_PEAK   = 3'd3;
    localparam logic [2:0] A_STATUS = 3'd4;
    localparam logic [2:0] A_LAST_X = 3'd5;

    state_t      state_q, state_d;
    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;
    logic [15:0] co_q, co_d;
    logic [15:0] seed_q, seed_d;
    logic [15:0] steps_q, steps_d;
    logic [15:0] peak_q, peak_d;
    logic [15:0] last_x_q, last_x_d;
    logic        irq_en_q, irq_en_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        to_q, to_d;
    logic [1:0]  wait_q, wait_d;
`ifdef COLLATZ_WB_CTRL_TIMEOUT_EN
    logic [31:0] cyc_q, cyc_d;
    logic        refuse_q, refuse_d;
`endif

    logic        req;
    logic        wr;
    logic [2:0]  adr;
    logic        start_ok;
    logic        fold;
    logic        count;
    logic        unused_ok;

    assign adr = wbs_adr_i[4:2];
    assign req = wbs_cyc_i & wbs_stb_i & ~ack_q;
    // Writes commit on the edge that ends the ack cycle; the master still holds the bus then.
    assign wr  = ack_q & wbs_cyc_i & wbs_stb_i & wbs_we_i & wbs_sel_i[0];

`ifdef COLLATZ_WB_CTRL_TIMEOUT_EN
    assign start_ok = ~bs_i & ~refuse_q;
`else
    assign start_ok = ~bs_i;
`endif

    assign unused_ok = ^{wbs_adr_i[31:5], wbs_adr_i[1:0], wbs_dat_i[31:16], wbs_sel_i[3:1],
                         TIMEOUT_CYCLES};

    always_comb begin
        state_d  = state_q;
        ack_d    = req;
        dat_d    = '0;
        co_d     = co_q;
        seed_d   = seed_q;
        steps_d  = steps_q;
        peak_d   = peak_q;
        last_x_d = last_x_q;
        irq_en_d = irq_en_q;
        done_d   = done_q;
        err_d    = err_q;
        to_d     = to_q;
        wait_d   = wait_q;
        fold     = 1'b0;
        count    = 1'b0;
`ifdef COLLATZ_WB_CTRL_TIMEOUT_EN
        cyc_d    = cyc_q;
        refuse_d = refuse_q;
        if (!bs_i) refuse_d = 1'b0;
`endif

        if (req && !wbs_we_i) begin
            case (adr)
                A_CTRL:   dat_d = {27'b0, to_q, err_q, done_q, irq_en_q, state_q != S_IDLE};
                A_SEED:   dat_d = {16'b0, seed_q};
                A_STEPS:  dat_d = {16'b0, steps_q};
                A_PEAK:   dat_d = {16'b0, peak_q};
                A_STATUS: dat_d = {29'b0, to_q, err_q, done_q};
                A_LAST_X: dat_d = {16'b0, last_x_q};
                default:  dat_d = '0;
            endcase
        end

        if (wr && adr == A_CTRL) irq_en_d = wbs_dat_i[1];
        if (wr && adr == A_SEED) seed_d = wbs_dat_i[15:0];
        // W1C clears are applied before any hardware set below so that the set wins.
        if (wr && adr == A_STATUS) begin
            if (wbs_dat_i[0]) done_d = 1'b0;
            if (wbs_dat_i[1]) err_d  = 1'b0;
            if (wbs_dat_i[2]) to_d   = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (wr && adr == A_CTRL && wbs_dat_i[0]) begin
                    if (seed_q == 16'd0) begin
                        err_d = 1'b1;
                    end else if (start_ok) begin
                        // Launch values are loaded here so co_o is valid while st_o is high.
                        state_d  = S_LAUNCH;
                        co_d     = seed_q;
                        steps_d  = 16'd0;
                        peak_d   = seed_q;
                        last_x_d = seed_q;
                        wait_d   = 2'd0;
`ifdef COLLATZ_WB_CTRL_TIMEOUT_EN
                        cyc_d    = 32'd0;
`endif
                    end
                end
            end
            S_LAUNCH: state_d = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                // The first busy cycle already carries the first trajectory value.
                if (bs_i) begin
                    fold    = 1'b1;
                    count   = 1'b1;
                    state_d = S_RUN;
                end else if (wait_q == 2'd3) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            S_RUN: begin
                fold = 1'b1;
                if (bs_i) begin
                    count = 1'b1;
                end else begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (fold) begin
            last_x_d = x_i;
            if (x_i > peak_q) peak_d = x_i;
        end
        if (count) begin
            steps_d = (steps_q == 16'hFFFF) ? steps_q : steps_q + 16'd1;
`ifdef COLLATZ_WB_CTRL_TIMEOUT_EN
            cyc_d = cyc_q + 32'd1;
            if (cyc_q + 32'd1 >= TIMEOUT_CYCLES) begin
                to_d     = 1'b1;
                done_d   = 1'b1;
                refuse_d = 1'b1;
                state_d  = S_IDLE;
            end
`endif
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q  <= S_IDLE;
            ack_q    <= 1'b0;
            dat_q    <= '0;
            co_q     <= '0;
            seed_q   <= '0;
            steps_q  <= '0;
            peak_q   <= '0;
            last_x_q <= '0;
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            to_q     <= 1'b0;
            wait_q   <= '0;
`ifdef COLLATZ_WB_CTRL_TIMEOUT_EN
            cyc_q    <= '0;
            refuse_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            dat_q    <= dat_d;
            co_q     <= co_d;
            seed_q   <= seed_d;
            steps_q  <= steps_d;
            peak_q   <= peak_d;
            last_x_q <= last_x_d;
            irq_en_q <= irq_en_d;
            done_q   <= done_d;
            err_q    <= err_d;
            to_q     <= to_d;
            wait_q   <= wait_d;
`ifdef COLLATZ_WB_CTRL_TIMEOUT_EN
            cyc_q    <= cyc_d;
            refuse_q <= refuse_d;
`endif
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign st_o      = (state_q == S_LAUNCH);
    assign co_o      = co_q;
    assign irq_o     = done_q & irq_en_q;

endmodule

// File: doc/collatz_wb_ctrl.md
# collatz_wb_ctrl

Wishbone-slave control and result-capture stage wrapped around the `collatz` core. It drives the core's start strobe and seed, and consumes the core's trajectory value and busy flag. It accumulates step count, peak value and final value for one run, and raises a completion interrupt. It sits between the wrapper's Wishbone port and the core, replacing direct bit-mapping of `wbs_dat_i`/`wbs_dat_o` onto core pins.

## Interface
- `TIMEOUT_CYCLES`, default 65535: run-length limit in cycles; used only when the timeout feature is compiled in.
- `wb_clk_i  in  1`: clock; all logic on the rising edge.
- `wb_rst_i  in  1`: synchronous, active-high reset.
- `wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1`: Wishbone classic cycle, strobe and write enable.
- `wbs_adr_i  in  32`: byte address; only `[4:2]` is decoded.
- `wbs_dat_i  in  32`: write data.
- `wbs_sel_i  in  4`: byte enables; a write updates a register only if `sel[0]` is set.
- `wbs_ack_o  out  1`: single-cycle acknowledge.
- `wbs_dat_o  out  32`: read data; unused bits are 0.
- `st_o  out  1`: one-cycle start pulse to the core.
- `co_o  out  16`: launched seed to the core.
- `x_i  in  16`: core trajectory value.
- `bs_i  in  1`: core busy.
- `irq_o  out  1`: level interrupt, equal to `done & irq_en`.

## Operation
- Register map, by `adr[4:2]`:
  - 0 CTRL: write bit0 START (self-clearing) and bit1 IRQ_EN. Read bit0 busy (FSM not IDLE), bit1 irq_en, bit2 done, bit3 err, bit4 timeout.
  - 1 SEED: read/write, `[15:0]`.
  - 2 STEPS: read-only.
  - 3 PEAK: read-only.
  - 4 STATUS: read returns done/err/timeout in bits 0/1/2; write 1 to clear each bit.
  - 5 LAST_X: read-only.
  - 6–7: reads return 0; writes are ignored.
- FSM states: IDLE, LAUNCH, WAIT_BUSY, RUN.
  - IDLE → LAUNCH on a START write when SEED≠0 and `bs_i`=0. A START with SEED=0 sets err and stays in IDLE. A START while `bs_i`=1 or the FSM is not in IDLE is ignored.
  - LAUNCH lasts one cycle. It asserts `st_o`, latches `co_o`←SEED, clears STEPS, sets PEAK←SEED and LAST_X←SEED, and clears the wait counter. Next state is WAIT_BUSY.
  - WAIT_BUSY → RUN when `bs_i`=1. If `bs_i` stays 0 for 4 cycles, the run completes with STEPS=0 (seed-1 case): set done, go to IDLE.
  - RUN, every cycle:
    - LAST_X←`x_i`.
    - PEAK←max(PEAK, `x_i`), unsigned.
    - If `bs_i`=1, STEPS increments, saturating at 0xFFFF.
    - If `bs_i`=0, set done and go to IDLE. `x_i` in this same cycle is still folded into PEAK and LAST_X.
- Writes to SEED during a run update the register only; `co_o` is unchanged.
- If a hardware set and a W1C clear of the same STATUS bit occur in the same cycle, the set wins.
- Reset during a run: the FSM returns to IDLE and every register clears. The core is reset by the same `wb_rst_i`.

## Timing
- Reset values: `wbs_ack_o`=0, `wbs_dat_o`=0, `st_o`=0, `co_o`=0, `irq_o`=0; all registers 0; FSM in IDLE.
- Wishbone:
  - `wbs_ack_o` asserts the cycle after `cyc & stb & !ack` and lasts exactly one cycle.
  - Read data is registered and valid with ack.
  - Write side effects take effect at the ack edge.
  - Back-to-back accesses therefore take 2 cycles each.
- START timing: the START write acks in cycle N, LAUNCH is cycle N+1, and `st_o` is high during N+1 only.
- done and `irq_o` rise in the cycle after RUN samples `bs_i`=0.
- Completion readback: STEPS, PEAK and LAST_X are stable from the cycle done rises, and a read issued in that cycle returns the final values.

## Configuration
- `COLLATZ_WB_CTRL_TIMEOUT_EN`
  - Defined:
    - RUN also counts cycles.
    - When the count reaches `TIMEOUT_CYCLES`, set timeout and done and go to IDLE.
    - A new START is then refused (ignored) until `bs_i` falls.
  - Undefined:
    - No cycle counter; RUN waits indefinitely.
    - The timeout bit reads as 0.

## Test plan
- Reset: after `wb_rst_i` is held 2 cycles, every output is 0 and reads of addresses 0–5 return 0.
- Normal run: SEED=6, then START. The core model holds `bs_i` high for 8 cycles presenting 3, 10, 5, 16, 8, 4, 2, 1 (no extra `x_i` value in the falling cycle), then drops `bs_i`. Required: `st_o` is one cycle long, `co_o`=6, STEPS=8, PEAK=16, LAST_X=1, done=1, and `irq_o`=1 when IRQ_EN is set.
- Seed 1: SEED=1 and START, with `bs_i` never rising. Required: done after 4 WAIT_BUSY cycles, STEPS=0, PEAK=1.
- Errors: START with SEED=0 sets err=1 with no `st_o`. A second START during RUN is ignored, and STEPS is unaffected.
- W1C race: a STATUS write of 0x1 landing in the same cycle done sets leaves done=1. A later write of 0x1 clears done and drops `irq_o`.
- Timeout (macro defined, `TIMEOUT_CYCLES`=20): with `bs_i` held high, timeout=1 and done=1 at cycle 20 of RUN, STEPS=20, and START is ignored until `bs_i`=0.
